// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and helpers for the systolic-array drain scheduler
package sa_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter width: must hold the last RUN value LAT+COL+ROWS-2
    function automatic int calc_w_cnt(input int lat, input int col, input int rows);
        return $clog2(lat + col + rows);
    endfunction

endpackage

// File: rtl/o_sa_drain_sched_skew_line.sv
// rtl/o_sa_drain_sched_skew_line.sv - N-stage one-bit shift line, stage i lags the input by i+1 cycles
module sa_skew_line #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         d,
    output logic [N-1:0] q
);

    generate
        if (N == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (clr) begin
                    q <= '0;
                end else begin
                    q <= d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (clr) begin
                    q <= '0;
                end else begin
                    q <= {q[N-2:0], d};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/o_sa_drain_sched.sv
// rtl/o_sa_drain_sched.sv - drain scheduler: latency wait, then column-skewed valid/last strobes
module o_sa_drain_sched
    import sa_pkg::*;
#(
    parameter int COL  = 3,
    parameter int ROWS = 3,
    parameter int LAT  = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_abort,
    output logic [COL-1:0] o_col_valid,
    output logic [COL-1:0] o_col_last,
    output logic           o_busy,
    output logic           o_done
);

    localparam int W_CNT = calc_w_cnt(LAT, COL, ROWS);
    localparam int LAST  = LAT + COL + ROWS - 2;
    localparam int V0_LO = LAT;
    localparam int V0_HI = LAT + ROWS - 1;

    state_t           state;
    state_t           state_nxt;
    logic [W_CNT-1:0] cnt;
    logic [W_CNT-1:0] cnt_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             abort_run;
    logic             v0_nxt;
    logic             l0_nxt;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Outputs are registered, so column-0 strobes are decoded from the next counter value
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        done_nxt  = 1'b0;
        abort_run = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                    abort_run = 1'b1;
                end else if (int'(cnt) == LAST) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + W_CNT'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt == ST_RUN);
        v0_nxt   = busy_nxt && (int'(cnt_nxt) >= V0_LO) && (int'(cnt_nxt) <= V0_HI);
        l0_nxt   = busy_nxt && (int'(cnt_nxt) == V0_HI);
    end

    sa_skew_line #(.N(COL)) u_valid_line (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (abort_run),
        .d     (v0_nxt),
        .q     (o_col_valid)
    );

    sa_skew_line #(.N(COL)) u_last_line (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (abort_run),
        .d     (l0_nxt),
        .q     (o_col_last)
    );

    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule
